// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with a valid/ready handshake and STAGES-cycle latency.
// Define SHIFT_FLAGS_EN to add the registered out_carry / out_zero result flags.
module pipe_shifter #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    localparam int SA_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_d,
    input  logic [SA_W-1:0]  in_sa,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sh
`ifdef SHIFT_FLAGS_EN
    ,
    output logic             out_carry,
    output logic             out_zero
`endif
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    logic [WIDTH-1:0] data_q [STAGES];
    logic [WIDTH-1:0] data_d [STAGES];
    logic [SA_W-1:0]  sa_q   [STAGES];
    logic [1:0]       op_q   [STAGES];
    logic             sign_q [STAGES];
    logic             vld_q  [STAGES];

    logic [WIDTH-1:0] src_data [STAGES];
    logic [SA_W-1:0]  src_sa   [STAGES];
    logic [1:0]       src_op   [STAGES];
    logic             src_sign [STAGES];
    logic             src_vld  [STAGES];

`ifdef SHIFT_FLAGS_EN
    logic carry_q [STAGES];
    logic carry_d [STAGES];
    logic src_carry [STAGES];
    logic zero_q, zero_d;
`endif

    logic advance;

    function automatic logic [WIDTH-1:0] shift_lvl(input logic [WIDTH-1:0] x,
                                                   input logic [1:0] op,
                                                   input logic sign,
                                                   input int amt);
        logic [WIDTH-1:0] fill;
        fill = sign ? ~({WIDTH{1'b1}} >> amt) : '0;
        case (op)
            OP_SLL:  return x << amt;
            OP_SRL:  return x >> amt;
            OP_SRA:  return (x >> amt) | fill;
            default: return (x >> amt) | (x << (WIDTH - amt));
        endcase
    endfunction

    // Stage 0 is fed from the request port, every later stage from its predecessor.
    for (genvar s = 0; s < STAGES; s++) begin : g_src
        if (s == 0) begin : g_head
            assign src_data[s] = in_d;
            assign src_sa[s]   = in_sa;
            assign src_op[s]   = in_op;
            assign src_sign[s] = in_d[WIDTH-1];
            assign src_vld[s]  = in_valid;
`ifdef SHIFT_FLAGS_EN
            assign src_carry[s] = 1'b0;
`endif
        end else begin : g_body
            assign src_data[s] = data_q[s-1];
            assign src_sa[s]   = sa_q[s-1];
            assign src_op[s]   = op_q[s-1];
            assign src_sign[s] = sign_q[s-1];
            assign src_vld[s]  = vld_q[s-1];
`ifdef SHIFT_FLAGS_EN
            assign src_carry[s] = carry_q[s-1];
`endif
        end
    end

    assign advance  = out_ready || !vld_q[STAGES-1];
    assign in_ready = advance;

    always_comb begin
        logic [WIDTH-1:0] x;
`ifdef SHIFT_FLAGS_EN
        logic c;
`endif
        x = '0;
`ifdef SHIFT_FLAGS_EN
        c = 1'b0;
`endif
        for (int s = 0; s < STAGES; s++) begin
            x = src_data[s];
`ifdef SHIFT_FLAGS_EN
            c = src_carry[s];
`endif
            // Barrel level k lives in stage floor(k*STAGES/SA_W).
            for (int k = 0; k < SA_W; k++) begin
                if (((k * STAGES) / SA_W) == s && src_sa[s][k]) begin
`ifdef SHIFT_FLAGS_EN
                    c = (src_op[s] == OP_SLL) ? x[WIDTH-(1<<k)] : x[(1<<k)-1];
`endif
                    x = shift_lvl(x, src_op[s], src_sign[s], 1 << k);
                end
            end
            data_d[s] = x;
`ifdef SHIFT_FLAGS_EN
            carry_d[s] = c;
`endif
        end
`ifdef SHIFT_FLAGS_EN
        // Rotate loses no bits; its carry is the final MSB.
        if (src_op[STAGES-1] == OP_ROR)
            carry_d[STAGES-1] = (src_sa[STAGES-1] != '0) && data_d[STAGES-1][WIDTH-1];
        zero_d = (data_d[STAGES-1] == '0);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
                sa_q[s]   <= '0;
                op_q[s]   <= '0;
                sign_q[s] <= 1'b0;
                vld_q[s]  <= 1'b0;
`ifdef SHIFT_FLAGS_EN
                carry_q[s] <= 1'b0;
`endif
            end
`ifdef SHIFT_FLAGS_EN
            zero_q <= 1'b0;
`endif
        end else if (advance) begin
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= data_d[s];
                sa_q[s]   <= src_sa[s];
                op_q[s]   <= src_op[s];
                sign_q[s] <= src_sign[s];
                vld_q[s]  <= src_vld[s];
`ifdef SHIFT_FLAGS_EN
                carry_q[s] <= carry_d[s];
`endif
            end
`ifdef SHIFT_FLAGS_EN
            zero_q <= zero_d;
`endif
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_sh    = data_q[STAGES-1];
`ifdef SHIFT_FLAGS_EN
    assign out_carry = carry_q[STAGES-1];
    assign out_zero  = zero_q;
`endif

endmodule

// File: tb/tb_pipe_shifter.sv
// Bench for pipe_shifter: directed vectors, latency at STAGES 1/2/5, backpressure, random traffic, reset.
module tb_pipe_shifter;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_d;
    logic [4:0]    in_sa;
    logic [1:0]    in_op;
    logic          out_ready;
    logic          rdy1, rdy2, rdy5;
    logic          ov1, ov2, ov5;
    logic [W-1:0]  sh1, sh2, sh5;
`ifdef SHIFT_FLAGS_EN
    logic cy1, cy2, cy5, zr1, zr2, zr5;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] sh;
        logic         cy;
        logic         zr;
    } exp_t;

    pipe_shifter #(.WIDTH(W), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_d(in_d), .in_sa(in_sa),
        .in_op(in_op), .out_valid(ov1), .out_ready(out_ready), .out_sh(sh1)
`ifdef SHIFT_FLAGS_EN
        , .out_carry(cy1), .out_zero(zr1)
`endif
    );

    pipe_shifter #(.WIDTH(W), .STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_d(in_d), .in_sa(in_sa),
        .in_op(in_op), .out_valid(ov2), .out_ready(out_ready), .out_sh(sh2)
`ifdef SHIFT_FLAGS_EN
        , .out_carry(cy2), .out_zero(zr2)
`endif
    );

    pipe_shifter #(.WIDTH(W), .STAGES(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy5), .in_d(in_d), .in_sa(in_sa),
        .in_op(in_op), .out_valid(ov5), .out_ready(out_ready), .out_sh(sh5)
`ifdef SHIFT_FLAGS_EN
        , .out_carry(cy5), .out_zero(zr5)
`endif
    );

    always #5 clk = ~clk;

    // Reference: whole-word arithmetic on the full shift amount.
    function automatic exp_t ref_model(input logic [W-1:0] d, input logic [4:0] sa, input logic [1:0] op);
        exp_t e;
        int   n;
        n = int'(sa);
        case (op)
            2'b00: e.sh = d << n;
            2'b01: e.sh = d >> n;
            2'b10: e.sh = W'($signed(d) >>> n);
            default: e.sh = (n == 0) ? d : ((d >> n) | (d << (W - n)));
        endcase
        if (n == 0)          e.cy = 1'b0;
        else if (op == 2'b00) e.cy = d[W-n];
        else if (op == 2'b11) e.cy = e.sh[W-1];
        else                 e.cy = d[n-1];
        e.zr = (e.sh == '0);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_d = '0; in_sa = '0; in_op = '0; out_ready = 1'b0;
        do_reset();
        checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b exp 0", ov2); end
        checks++; if (sh2 !== '0) begin errors++; $display("FAIL reset out_sh got %h exp 0", sh2); end
        checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b exp 1", rdy2); end
`ifdef SHIFT_FLAGS_EN
        checks++; if ({cy2, zr2} !== 2'b00) begin errors++; $display("FAIL reset flags got %b exp 00", {cy2, zr2}); end
`endif
    endtask

    task automatic test_ops();
        logic [W-1:0] td [4] = '{32'h00000001, 32'h80000000, 32'h80000000, 32'h000000F1};
        logic [4:0]   ts [4] = '{5'd31, 5'd4, 5'd4, 5'd4};
        logic [1:0]   to [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [W-1:0] tx [4] = '{32'h80000000, 32'h08000000, 32'hF8000000, 32'h1000000F};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_d = td[i]; in_sa = ts[i]; in_op = to[i];
            step();
            in_valid = 1'b0;
            checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL ops[%0d] early out_valid got %b exp 0", i, ov2); end
            step();
            checks++; if (ov2 !== 1'b1) begin errors++; $display("FAIL ops[%0d] out_valid got %b exp 1", i, ov2); end
            checks++; if (sh2 !== tx[i]) begin errors++; $display("FAIL ops[%0d] out_sh got %h exp %h", i, sh2, tx[i]); end
            step();
        end
    endtask

    task automatic test_sa_zero();
        logic [W-1:0] td [5] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h80000000};
        logic [4:0]   ts [5] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd1};
        logic [1:0]   to [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        logic [W-1:0] tx [5] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        logic [1:0]   tf [5] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_d = td[i]; in_sa = ts[i]; in_op = to[i];
            step();
            in_valid = 1'b0;
            step();
            checks++; if (!(ov2 === 1'b1 && sh2 === tx[i])) begin
                errors++; $display("FAIL sa_zero[%0d] valid/out_sh got %b/%h exp 1/%h", i, ov2, sh2, tx[i]);
            end
`ifdef SHIFT_FLAGS_EN
            checks++; if ({cy2, zr2} !== tf[i]) begin
                errors++; $display("FAIL sa_zero[%0d] carry,zero got %b exp %b", i, {cy2, zr2}, tf[i]);
            end
`else
            if (tf[i] === 2'bxx) $display("unreachable");
`endif
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] rd [4];
        logic [4:0]   rs [4];
        logic [1:0]   ro [4];
        exp_t         ex [4];
        int           lat [3] = '{1, 2, 5};
        logic         v;
        logic [W-1:0] sh;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd[i] = $urandom; rs[i] = 5'($urandom_range(1, 31)); ro[i] = 2'($urandom_range(0, 3));
            ex[i] = ref_model(rd[i], rs[i], ro[i]);
        end
        for (int c = 1; c <= 10; c++) begin
            if (c <= 4) begin
                in_valid = 1'b1; in_d = rd[c-1]; in_sa = rs[c-1]; in_op = ro[c-1];
            end else begin
                in_valid = 1'b0;
            end
            step();
            for (int j = 0; j < 3; j++) begin
                case (j)
                    0: begin v = ov1; sh = sh1; end
                    1: begin v = ov2; sh = sh2; end
                    default: begin v = ov5; sh = sh5; end
                endcase
                checks++;
                if (v !== (c >= lat[j] && c < lat[j] + 4)) begin
                    errors++; $display("FAIL b2b lat%0d cycle %0d out_valid got %b", lat[j], c, v);
                end else if (v && sh !== ex[c-lat[j]].sh) begin
                    errors++; $display("FAIL b2b lat%0d cycle %0d out_sh got %h exp %h", lat[j], c, sh, ex[c-lat[j]].sh);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t ex [3];
        logic [W-1:0] rd [3];
        int got = 0;
        for (int i = 0; i < 3; i++) begin
            rd[i] = $urandom;
            ex[i] = ref_model(rd[i], 5'd3, 2'b01);
        end
        in_sa = 5'd3; in_op = 2'b01; out_ready = 1'b1;
        in_valid = 1'b1; in_d = rd[0];
        step();
        in_d = rd[1]; out_ready = 1'b0;
        step();
        in_d = rd[2];
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (!(ov2 === 1'b1 && rdy2 === 1'b0 && sh2 === ex[0].sh)) begin
                errors++; $display("FAIL stall[%0d] valid/ready/out_sh got %b/%b/%h exp 1/0/%h", i, ov2, rdy2, sh2, ex[0].sh);
            end
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic acc;
            #1;
            acc = in_valid && rdy2;
            if (ov2) begin
                checks++;
                if (got >= 3) begin
                    errors++; $display("FAIL stall duplicate result %h", sh2);
                end else if (sh2 !== ex[got].sh) begin
                    errors++; $display("FAIL stall drain[%0d] out_sh got %h exp %h", got, sh2, ex[got].sh);
                end
                got++;
            end
            step();
            if (acc) in_valid = 1'b0;
        end
        checks++; if (got != 3) begin errors++; $display("FAIL stall delivered got %0d exp 3", got); end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        logic prev_stall = 1'b0;
        logic [W-1:0] prev_sh = '0;
        for (int i = 0; i < 400 + 20; i++) begin
            if (i < 400) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_d = $urandom;
                in_sa = 5'($urandom);
                in_op = 2'($urandom);
                out_ready = ($urandom_range(0, 9) < 7);
            end else begin
                in_valid = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            checks++; if (rdy2 !== (out_ready || !ov2)) begin
                errors++; $display("FAIL rnd[%0d] in_ready got %b", i, rdy2);
            end
            if (ov2 && prev_stall) begin
                checks++; if (sh2 !== prev_sh) begin
                    errors++; $display("FAIL rnd[%0d] stalled out_sh moved got %h exp %h", i, sh2, prev_sh);
                end
            end
            if (ov2 && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rnd[%0d] unexpected result %h", i, sh2);
                end else begin
                    e = q.pop_front();
                    if (sh2 !== e.sh) begin
                        errors++; $display("FAIL rnd[%0d] out_sh got %h exp %h", i, sh2, e.sh);
                    end
`ifdef SHIFT_FLAGS_EN
                    else if ({cy2, zr2} !== {e.cy, e.zr}) begin
                        errors++; $display("FAIL rnd[%0d] carry,zero got %b exp %b", i, {cy2, zr2}, {e.cy, e.zr});
                    end
`endif
                end
            end
            if (in_valid && rdy2) q.push_back(ref_model(in_d, in_sa, in_op));
            prev_stall = ov2 && !out_ready;
            prev_sh = sh2;
            step();
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd lost results got %0d pending exp 0", q.size()); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_d = $urandom; in_sa = 5'd7; in_op = 2'b00;
            step();
        end
        in_valid = 1'b0;
        #2;
        checks++; if (ov2 !== 1'b1) begin errors++; $display("FAIL midrst pre out_valid got %b exp 1", ov2); end
        rst = 1'b1;
        #1;
        checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL midrst async out_valid got %b exp 0", ov2); end
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL midrst post[%0d] out_valid got %b exp 0", i, ov2); end
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_ops();
        test_sa_zero();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
